// File: rtl/ysyx_220053_pkg.sv
// ysyx_220053_pkg: shared FSM states, trap codes and reset PC for the core sequencer
package ysyx_220053_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DECODE, EXEC, WB, HALT} state_t;
  localparam logic [1:0] TRAP_NONE = 2'd0;
  localparam logic [1:0] TRAP_EBREAK = 2'd1;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd2;
  localparam logic [1:0] TRAP_TIMEOUT = 2'd3;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
endpackage

// File: rtl/ysyx_220053_exec_sequencer_if.sv
// ysyx_220053_exec_sequencer_if: instruction-memory request/valid handshake
interface ysyx_220053_exec_sequencer_if;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_ready;
  logic imem_rvalid;
  logic [31:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ready, imem_rvalid, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/ysyx_220053_timeout_cnt.sv
// ysyx_220053_timeout_cnt: 16-bit saturating counter; hit compares the count including this cycle's increment
module ysyx_220053_timeout_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] limit,
  output logic        hit
);
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  assign cnt_nxt = (cnt == 16'hffff) ? cnt : cnt + 16'd1;
  // so a limit of N trips on the N-th enabled cycle
  assign hit = en & (cnt_nxt == limit);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt_nxt;
endmodule

// File: rtl/ysyx_220053_exec_sequencer.sv
// ysyx_220053_exec_sequencer: multi-cycle fetch/decode/exec/writeback control FSM with PC and trap handling
module ysyx_220053_exec_sequencer
  import ysyx_220053_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                                clk,
  input  logic                                rst_n,
  ysyx_220053_exec_sequencer_if.master        imem,
  output logic [31:0]                         instr_o,
  input  logic                                dec_legal,
  input  logic                                dec_ebreak,
  input  logic                                dec_wen,
  input  logic [31:0]                         next_pc_i,
  output logic [31:0]                         pc_o,
  output logic                                rf_wen_o,
  output logic                                retire_o,
  output logic [31:0]                         instret_o,
  output logic                                halt_o,
  output logic [1:0]                          trap_code_o
);
  state_t state;
  logic wen_q;
  logic hit;
  assign imem.imem_addr = pc_o;
  ysyx_220053_timeout_cnt u_timeout (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state != WAIT),
    .en(state == WAIT),
    .limit(16'(MEM_TIMEOUT)),
    .hit(hit)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc_o <= RESET_PC;
      instr_o <= '0;
      imem.imem_req <= 1'b0;
      rf_wen_o <= 1'b0;
      retire_o <= 1'b0;
      instret_o <= '0;
      halt_o <= 1'b0;
      trap_code_o <= TRAP_NONE;
      wen_q <= 1'b0;
    end else begin
      rf_wen_o <= 1'b0;
      retire_o <= 1'b0;
      case (state)
        IDLE: begin
          state <= FETCH;
          imem.imem_req <= 1'b1;
        end
        FETCH: if (imem.imem_ready) begin
          state <= WAIT;
          imem.imem_req <= 1'b0;
        end
        WAIT: if (imem.imem_rvalid) begin
          instr_o <= imem.imem_rdata;
          state <= DECODE;
        end else if (hit) begin
          state <= HALT;
          halt_o <= 1'b1;
          trap_code_o <= TRAP_TIMEOUT;
        end
        DECODE: if (dec_ebreak) begin
          state <= HALT;
          halt_o <= 1'b1;
          trap_code_o <= TRAP_EBREAK;
          retire_o <= 1'b1;
          instret_o <= instret_o + 32'd1;
        end else if (!dec_legal) begin
          state <= HALT;
          halt_o <= 1'b1;
          trap_code_o <= TRAP_ILLEGAL;
        end else begin
          wen_q <= dec_wen;
          state <= EXEC;
        end
        EXEC: if (|next_pc_i[1:0]) begin
          state <= HALT;
          halt_o <= 1'b1;
          trap_code_o <= TRAP_ILLEGAL;
        end else begin
          state <= WB;
          pc_o <= next_pc_i;
          rf_wen_o <= wen_q;
          retire_o <= 1'b1;
          instret_o <= instret_o + 32'd1;
        end
        WB: begin
          state <= FETCH;
          imem.imem_req <= 1'b1;
        end
        default: ;
      endcase
    end
endmodule
